// File: rtl/unrot_pkg.sv
// Shared types and helpers for the multi-cycle inverse rotator.
// Holds the FSM state encoding, default sizes and the one-position rotate steps.
package unrot_pkg;

  localparam int UNROT_WIDTH = 8;
  localparam int UNROT_AMT_W = $clog2(UNROT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [UNROT_WIDTH-1:0] rotl1(input logic [UNROT_WIDTH-1:0] x);
    return {x[UNROT_WIDTH-2:0], x[UNROT_WIDTH-1]};
  endfunction

  function automatic logic [UNROT_WIDTH-1:0] rotr1(input logic [UNROT_WIDTH-1:0] x);
    return {x[0], x[UNROT_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/rot1_step.sv
// Combinational one-position rotator: dir=1 rotates left, dir=0 rotates right.
module rot1_step
  import unrot_pkg::*;
#(
  parameter int WIDTH = UNROT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic             dir,
  output logic [WIDTH-1:0] y
);

  // Package helpers are sized for the default width; other widths use the same slicing inline.
  generate
    if (WIDTH == UNROT_WIDTH) begin : g_pkg
      assign y = dir ? rotl1(x) : rotr1(x);
    end else begin : g_gen
      assign y = dir ? {x[WIDTH-2:0], x[WIDTH-1]} : {x[0], x[WIDTH-1:1]};
    end
  endgenerate

endmodule

// File: rtl/unrot_seq_8bit.sv
// Multi-cycle inverse rotator: undoes an amt-position rotation in direction lr,
// one position per cycle in the opposite direction, with valid/ready on both sides.
module unrot_seq_8bit
  import unrot_pkg::*;
#(
  parameter int WIDTH = UNROT_WIDTH,
  parameter int AMT_W = UNROT_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             lr,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] step_w;

  // dir_q holds the original direction; rotating left undoes an original right rotation.
  rot1_step #(.WIDTH(WIDTH)) u_step (
    .x   (word_q),
    .dir (dir_q),
    .y   (step_w)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = a;
          dir_d   = lr;
          cnt_d   = amt;
          state_d = (amt == '0) ? DONE : ROT;
        end
      end
      ROT: begin
        word_d = step_w;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = word_q;

endmodule
